// File: rtl/memory_responder_if.sv
// RAM-port bus between the control unit (master) and the memory responder (slave).
`timescale 1ns/1ps
interface memory_responder_if;
    logic        ram_read;
    logic        ram_write;
    logic [22:0] ram_address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output ram_read, ram_write, ram_address, write_data,
        input  read_data
    );

    modport slave (
        input  ram_read, ram_write, ram_address, write_data,
        output read_data
    );
endinterface

// File: rtl/memory_responder.sv
// Zero-latency RAM plus MMIO page (buffered 8N1 UART transmitter, free-running cycle counter).
`timescale 1ns/1ps
module memory_responder #(
    parameter int MEM_WORDS    = 4096,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                nreset,
    memory_responder_if.slave   bus,
    output logic                uart_tx
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    FULL_CNT  = 3'(FIFO_DEPTH);
    localparam logic [21:0]   OFF_TXDATA = 22'd0;
    localparam logic [21:0]   OFF_STATUS = 22'd1;
    localparam logic [21:0]   OFF_CYCLE  = 22'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic          is_mmio, sel_txdata, sel_status, sel_cycle;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram [MEM_WORDS];

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    fifo_count;
    logic          fifo_full, fifo_empty, push_req, push, pop, overflow;

    logic [31:0]   cycle;

    tx_state_t     state, state_next;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shifter;
    logic          tick_last, tx_busy;

    assign is_mmio    = bus.ram_address[22];
    assign ram_idx    = bus.ram_address[AW-1:0];
    assign sel_txdata = is_mmio && (bus.ram_address[21:0] == OFF_TXDATA);
    assign sel_status = is_mmio && (bus.ram_address[21:0] == OFF_STATUS);
    assign sel_cycle  = is_mmio && (bus.ram_address[21:0] == OFF_CYCLE);

    // RAM contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (bus.ram_write && !is_mmio)
            ram[ram_idx] <= bus.write_data;
    end

    assign fifo_full  = (fifo_count == FULL_CNT);
    assign fifo_empty = (fifo_count == 3'd0);
    assign push_req   = bus.ram_write && sel_txdata;
    // A pop at the same edge frees a slot, so a push into a full FIFO still lands.
    assign push       = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bus.write_data[7:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && fifo_full && !pop)
                overflow <= 1'b1;
            else if (bus.ram_write && sel_status && bus.write_data[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            cycle <= '0;
        else if (bus.ram_write && sel_cycle)
            cycle <= bus.write_data;
        else
            cycle <= cycle + 32'd1;
    end

    assign tick_last = (clk_cnt == TICK_LAST);
    assign tx_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: if (tick_last) state_next = DATA;
            DATA:  if (tick_last && bit_cnt == 3'd7) state_next = STOP;
            STOP: begin
                if (tick_last) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            clk_cnt <= (state == IDLE || tick_last) ? '0 : clk_cnt + 1'b1;
            if (state != DATA)
                bit_cnt <= '0;
            else if (tick_last)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop)
            shifter <= fifo_mem[rd_ptr];
        else if (state == DATA && tick_last)
            shifter <= {1'b0, shifter[7:1]};
    end

    // Decoded from state so an asynchronous reset forces the line idle at once.
    always_comb begin
        case (state)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shifter[0];
            default: uart_tx = 1'b1;
        endcase
    end

    always_comb begin
        bus.read_data = '0;
        if (bus.ram_read) begin
            if (!is_mmio)
                bus.read_data = ram[ram_idx];
            else if (sel_status)
                bus.read_data = {25'd0, fifo_count, overflow, tx_busy, fifo_empty, fifo_full};
            else if (sel_cycle)
                bus.read_data = cycle;
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: RAM, MMIO registers and UART framing with CLKS_PER_BIT=4.
`timescale 1ns/1ps
module tb_memory_responder;
  localparam int MEM_WORDS  = 4096;
  localparam int CPB        = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CPB;
  localparam logic [22:0] A_TXDATA = 23'h400000;
  localparam logic [22:0] A_STATUS = 23'h400001;
  localparam logic [22:0] A_CYCLE  = 23'h400002;
  localparam logic [63:0] IDLE_FRAME = (64'd1 << FRAME) - 64'd1;

  logic clk = 1'b0;
  logic nreset;
  logic uart_tx;

  memory_responder_if bus();

  memory_responder #(
    .MEM_WORDS(MEM_WORDS),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // uart_tx is sampled mid-cycle into a log while enabled
  logic log_buf [0:511];
  int   log_n  = 0;
  logic log_en = 1'b0;

  always @(negedge clk) begin
    if (log_en && log_n < 512) begin
      log_buf[log_n] = uart_tx;
      log_n = log_n + 1;
    end
  end

  function automatic logic [63:0] make_frame(input logic [7:0] b);
    logic [63:0] v;
    int p;
    v = '0;
    for (int j = 0; j < FRAME; j++) begin
      p = j / CPB;
      if (p == 0)      v[j] = 1'b0;
      else if (p == 9) v[j] = 1'b1;
      else             v[j] = b[p-1];
    end
    return v;
  endfunction

  function automatic logic [63:0] log_chunk(input int start);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < FRAME; j++) v[j] = log_buf[start + j];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [22:0] a, input logic [31:0] d);
    bus.ram_read    = 1'b0;
    bus.ram_write   = 1'b1;
    bus.ram_address = a;
    bus.write_data  = d;
    @(posedge clk);
    #1;
    bus.ram_write   = 1'b0;
  endtask

  task automatic rd(input logic [22:0] a, output logic [31:0] d);
    bus.ram_read    = 1'b1;
    bus.ram_address = a;
    #1;
    d = bus.read_data;
    bus.ram_read    = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  ovf_bytes [6];
    logic [7:0]  sent_bytes [6];
    ovf_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sent_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};

    bus.ram_read    = 1'b0;
    bus.ram_write   = 1'b0;
    bus.ram_address = '0;
    bus.write_data  = '0;
    nreset          = 1'b0;

    // reset state
    #3;
    check("rst_uart_tx", uart_tx, 1);
    check("rst_rdata_idle", bus.read_data, 0);
    rd(A_STATUS, d); check("rst_status", d, 32'h2);
    rd(A_CYCLE, d);  check("rst_cycle", d, 0);
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;

    // cycle counter
    tick(10);
    rd(A_CYCLE, d); check("cycle_n10", d, 10);
    wr(A_CYCLE, 32'hFFFF_FFFF);
    rd(A_CYCLE, d); check("cycle_load", d, 32'hFFFF_FFFF);
    tick(1);
    rd(A_CYCLE, d); check("cycle_wrap", d, 0);

    // RAM write, read, alias, gating, read-during-write
    wr(23'h10, 32'hDEAD_BEEF);
    rd(23'h10, d); check("ram_read", d, 32'hDEAD_BEEF);
    rd(23'(16 + MEM_WORDS), d); check("ram_alias", d, 32'hDEAD_BEEF);
    bus.ram_address = 23'h10;
    bus.ram_read    = 1'b0;
    #1 check("rdata_gated", bus.read_data, 0);
    bus.ram_read   = 1'b1;
    bus.ram_write  = 1'b1;
    bus.write_data = 32'h1234_5678;
    #1 check("rw_prewrite", bus.read_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 bus.ram_write = 1'b0;
    check("rw_postwrite", bus.read_data, 32'h1234_5678);
    bus.ram_read = 1'b0;
    wr(23'h20, 32'hCAFE_F00D);
    rd(A_TXDATA, d);     check("txdata_read_zero", d, 0);
    rd(23'h400003, d);   check("unmapped_read_zero", d, 0);

    // single byte frame
    tick(1);
    log_n = 0; log_en = 1'b1;
    wr(A_TXDATA, 32'h41);
    tick(20);
    rd(A_STATUS, d); check("busy_mid_frame", d[2], 1);
    tick(21);
    rd(A_STATUS, d); check("status_after_frame", d, 32'h2);
    tick(60);
    log_en = 1'b0;
    check("idle_before_start", log_buf[1], 1);
    check("frame_0x41", log_chunk(2), make_frame(8'h41));
    check("idle_after_0x41", log_chunk(2 + FRAME), IDLE_FRAME);

    // overflow, clear, push+pop while full, back-to-back frames
    tick(1);
    log_n = 0; log_en = 1'b1;
    for (int i = 0; i < 6; i++) wr(A_TXDATA, {24'd0, ovf_bytes[i]});
    rd(A_STATUS, d); check("status_overflow", d, 32'h4D);
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, d); check("status_ovf_clear", d, 32'h45);
    tick(34);
    wr(A_TXDATA, 32'h77);
    rd(A_STATUS, d); check("status_push_pop_full", d, 32'h45);
    tick(250);
    log_en = 1'b0;
    check("ovf_idle_before", log_buf[1], 1);
    for (int i = 0; i < 6; i++)
      check($sformatf("ovf_frame%0d", i), log_chunk(2 + i * FRAME), make_frame(sent_bytes[i]));
    check("ovf_idle_after", log_chunk(2 + 6 * FRAME), IDLE_FRAME);

    // reset mid-frame
    tick(1);
    wr(A_TXDATA, 32'hA5);
    wr(A_TXDATA, 32'h5A);
    tick(9);
    check("tx_data_bit1", uart_tx, 0);
    nreset = 1'b0;
    #1 check("tx_async_reset", uart_tx, 1);
    @(posedge clk);
    #1 nreset = 1'b1;
    tick(2);
    rd(A_STATUS, d);   check("status_after_reset", d, 32'h2);
    rd(23'h10, d);     check("ram_kept_0x10", d, 32'h1234_5678);
    rd(23'h20, d);     check("ram_kept_0x20", d, 32'hCAFE_F00D);
    log_n = 0; log_en = 1'b1;
    tick(45);
    log_en = 1'b0;
    check("idle_after_reset", log_chunk(0), IDLE_FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/memory_responder.md
# memory_responder

Memory-side responder for the CPU's RAM port: services the fetch, load and store traffic issued by the control unit (ram_read / ram_write / ram_address), returning data combinationally in the same cycle. The 23-bit address space is split into a word-addressed data/instruction RAM and a small MMIO page. The MMIO page holds a buffered 8N1 UART console transmitter and a free-running cycle counter. The block never stalls the initiator; every access completes in the cycle it is presented.

## Interface
- MEM_WORDS, 4096, RAM depth in 32-bit words; power of two.
- CLKS_PER_BIT, 16, clk cycles per UART bit; ≥ 2.
- FIFO_DEPTH, 4, TX byte FIFO depth; power of two, ≤ 4.

Ports:
- clk  input  1  clock.
- nreset  input  1  reset, asynchronous, active-low.
- ram_read  input  1  read strobe.
- ram_write  input  1  write strobe, sampled at posedge clk.
- ram_address  input  23  word address.
- write_data  input  32  store data.
- read_data  output  32  read data, combinational.
- uart_tx  output  1  serial console line; idle high.

## Operation
- Address decode:
  - ram_address[22]=0: RAM, index = ram_address[log2(MEM_WORDS)-1:0]. Upper bits are ignored, so accesses alias (wrap).
  - ram_address[22]=1: MMIO.
- RAM:
  - Asynchronous read.
  - Synchronous write at posedge when ram_write=1.
  - Contents are not cleared by nreset.
- MMIO registers:
  - 0x400000 TXDATA: a write pushes write_data[7:0] into the FIFO. Reads return 0.
  - 0x400001 STATUS (read): bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow (sticky), bits[6:4] fifo count, other bits 0. A write with write_data[3]=1 clears overflow; all other write bits are ignored.
  - 0x400002 CYCLE: 32-bit counter that increments every cycle and wraps 0xFFFFFFFF→0. A write loads write_data, and increments resume on the following edge.
  - Other MMIO addresses: reads return 0, writes are ignored.
- read_data = 0 whenever ram_read=0.
- ram_read and ram_write together: read_data shows pre-write contents, and the write occurs at the edge.
- FIFO:
  - A push when full is dropped and sets overflow.
  - A push and a pop at the same edge while full: the push is accepted and count is unchanged.
  - A push and a pop at the same edge while empty does not occur, because pops require non-empty.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into the shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT each → STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the last cycle, if FIFO non-empty, pop and go directly to START (no gap); otherwise go to IDLE.
  - tx_busy = (state != IDLE).

## Timing
- Reset values: uart_tx=1, FSM IDLE, FIFO empty (count 0), overflow 0, CYCLE 0, read_data 0 (ram_read low).
- Read latency: 0 cycles. read_data is valid in the same cycle as address/ram_read, which is required for the control unit to capture the instruction or load at the next posedge.
- Write latency: visible to reads immediately after the write edge.
- UART timing:
  - TXDATA write sampled at edge k with FSM IDLE: pop at edge k+1, uart_tx falls after k+1.
  - Frame = 10·CLKS_PER_BIT cycles.
  - Back-to-back frame period is exactly 10·CLKS_PER_BIT.
- Counter/status timing:
  - CYCLE read in cycle n after reset release returns n. The first posedge after release gives 1.
  - STATUS reflects register state before the current edge.
- Reset mid-frame: uart_tx goes high immediately (async), FIFO is flushed, the partial frame is abandoned, and RAM is retained.

## Test plan
- **RAM write/read/alias:** write 0xDEADBEEF to 0x000010, then read 0x000010 and 0x000010+MEM_WORDS → read_data=0xDEADBEEF in the same cycle for both reads; with ram_read=0, read_data=0.
- **Single byte (CLKS_PER_BIT=4):** write 0x41 to 0x400000 → uart_tx low 4 cycles starting at edge+1, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles. STATUS bit2=1 during the frame and 0 after 40 cycles.
- **Overflow:** write 6 bytes to TXDATA on consecutive cycles (FIFO_DEPTH=4).
  - Byte0 is popped at once; bytes1–4 fill the FIFO; byte5 is dropped.
  - STATUS then reads overflow=1, full=1, count=4.
  - Exactly bytes0–4 appear on uart_tx, back-to-back with no gap.
- **Overflow clear:** write 0x8 to 0x400001 → STATUS bit3=0; other fields unchanged.
- **Cycle counter:** read CYCLE 10 cycles after reset release → 10. Write 0xFFFFFFFF → next read 0xFFFFFFFF, following cycle 0x00000000.
- **Reset mid-frame:** assert nreset low during DATA → uart_tx=1 asynchronously. After release, STATUS reads empty, not busy, count=0, and a previously written RAM word is unchanged.
